// File: rtl/efpga_cfg_uart_tx.sv
// efpga_cfg_uart_tx: UART 8N1 transmitter feeding the eFPGA serial
// configuration port. Bytes enter on a valid/ready interface with a
// frame-end marker (tx_last) and are sent LSB first. bytes_sent counts
// data bytes completed in the current/last frame.
//
// Optional build macro EFPGA_CFG_TX_CHECKSUM_EN: appends an 8-bit
// mod-256 sum of the frame's data bytes as one extra character after the
// tx_last byte. The checksum character is not counted in bytes_sent.
//
// Timing (CPB = CLKS_PER_BIT): handshake in cycle t, start bit t+1..t+CPB,
// stop bit ends at t+10*CPB, tx_ready high again at t+10*CPB+1.

module efpga_cfg_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic             Tx,
    output logic             tx_active,
    output logic [CNT_W-1:0] bytes_sent
);

    // Bit-period counter width; CLKS_PER_BIT >= 2 keeps this >= 1.
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BIT_END = BCW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CSUM_LOAD
    } state_t;

    state_t         state;
    logic [BCW-1:0] bit_cnt;     // cycles elapsed in the current bit
    logic [2:0]     bit_idx;     // data bit on the line while in DATA
    logic [7:0]     data_q;      // character being serialised
    logic           last_q;      // current byte closes the frame
    logic           frame_open;  // a frame has started and not yet ended

    wire bit_done = (bit_cnt == BIT_END);
    wire take     = tx_valid & tx_ready;

`ifdef EFPGA_CFG_TX_CHECKSUM_EN
    logic [7:0] csum;            // running mod-256 sum of frame data bytes
    logic       in_csum;         // the character on the line is the checksum
`endif

    // Serialiser FSM; every output is a register updated with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            frame_open <= 1'b0;
            Tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_active  <= 1'b0;
            bytes_sent <= '0;
`ifdef EFPGA_CFG_TX_CHECKSUM_EN
            csum       <= '0;
            in_csum    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (take) begin
                        data_q     <= tx_data;
                        last_q     <= tx_last;
                        frame_open <= 1'b1;
                        // First byte of a new frame restarts the count.
                        if (!frame_open)
                            bytes_sent <= '0;
`ifdef EFPGA_CFG_TX_CHECKSUM_EN
                        csum <= frame_open ? (csum + tx_data) : tx_data;
`endif
                        bit_cnt   <= '0;
                        state     <= START;
                        Tx        <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_active <= 1'b1;
                    end
                end

                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        Tx      <= data_q[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            Tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            Tx      <= data_q[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
`ifdef EFPGA_CFG_TX_CHECKSUM_EN
                        if (in_csum) begin
                            // Checksum character done: frame complete.
                            in_csum   <= 1'b0;
                            state     <= IDLE;
                            tx_ready  <= 1'b1;
                            tx_active <= 1'b0;
                        end else begin
                            bytes_sent <= bytes_sent + CNT_W'(1);
                            if (last_q) begin
                                frame_open <= 1'b0;
                                state      <= CSUM_LOAD;
                            end else begin
                                state     <= IDLE;
                                tx_ready  <= 1'b1;
                                tx_active <= 1'b0;
                            end
                        end
`else
                        bytes_sent <= bytes_sent + CNT_W'(1);
                        if (last_q)
                            frame_open <= 1'b0;
                        state     <= IDLE;
                        tx_ready  <= 1'b1;
                        tx_active <= 1'b0;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end

`ifdef EFPGA_CFG_TX_CHECKSUM_EN
                CSUM_LOAD: begin
                    // One idle-high cycle, then the sum goes out as a character.
                    data_q  <= csum;
                    in_csum <= 1'b1;
                    bit_cnt <= '0;
                    Tx      <= 1'b0;
                    state   <= START;
                end
`endif

                default: begin
                    state     <= IDLE;
                    Tx        <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efpga_cfg_uart_tx.sv
// Bench for efpga_cfg_uart_tx. Two instances share the byte inputs:
// A (CPB=4, 16-bit count) and B (CPB=2, 4-bit count); sel steers tx_valid
// and the observed outputs. The reference model expands each frame into an
// expected per-cycle line waveform from the 8N1 framing rules.
module tb_efpga_cfg_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tx_valid, tx_last, sel;
    logic [7:0] tx_data;
    logic       va, vb;
    logic       rdy_a, tx_a, act_a, rdy_b, tx_b, act_b;
    logic [15:0] bs_a;
    logic [3:0]  bs_b;

    assign va = tx_valid & ~sel;
    assign vb = tx_valid & sel;

    efpga_cfg_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(va),
        .tx_last(tx_last), .tx_ready(rdy_a), .Tx(tx_a),
        .tx_active(act_a), .bytes_sent(bs_a));

    efpga_cfg_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vb),
        .tx_last(tx_last), .tx_ready(rdy_b), .Tx(tx_b),
        .tx_active(act_b), .bytes_sent(bs_b));

    logic        o_tx, o_rdy, o_act;
    logic [15:0] o_bs;
    assign o_tx  = sel ? tx_b  : tx_a;
    assign o_rdy = sel ? rdy_b : rdy_a;
    assign o_act = sel ? act_b : act_a;
    assign o_bs  = sel ? {12'd0, bs_b} : bs_a;

    int vecs = 0;
    int errs = 0;

    bit         exp_tx[$];
    bit         exp_rdy[$];
    bit         exp_hs[$];
    logic [7:0] frame_q[$];

    task automatic push_cyc(input bit t, input bit r, input bit h);
        exp_tx.push_back(t);
        exp_rdy.push_back(r);
        exp_hs.push_back(h);
    endtask

    // One 8N1 character: start, 8 data bits LSB first, stop; each c cycles.
    task automatic push_char(input logic [7:0] v, input int c);
        for (int j = 0; j < c; j++) push_cyc(1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < c; j++) push_cyc(v[b], 1'b0, 1'b0);
        for (int j = 0; j < c; j++) push_cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Sends frame_q back to back (tx_valid held) on the selected instance
    // and checks line, ready, active and bytes_sent every cycle.
    task automatic check_frame(input string tag);
        int n, cpb, bmod, bi;
        logic [7:0] sum;
        n    = frame_q.size();
        cpb  = sel ? 2 : 4;
        bmod = sel ? 16 : 65536;
        exp_tx.delete(); exp_rdy.delete(); exp_hs.delete();
        sum = 8'd0;
        for (int k = 0; k < n; k++) begin
            push_cyc(1'b1, 1'b1, 1'b1);
            push_char(frame_q[k], cpb);
            sum = sum + frame_q[k];
        end
`ifdef EFPGA_CFG_TX_CHECKSUM_EN
        push_cyc(1'b1, 1'b0, 1'b0);
        push_char(sum, cpb);
`endif
        push_cyc(1'b1, 1'b1, 1'b0);

        bi       = 0;
        tx_valid = 1'b1;
        tx_data  = frame_q[0];
        tx_last  = (n == 1);
        for (int i = 0; i < exp_tx.size(); i++) begin
            @(negedge clk);
            vecs++;
            if (o_tx !== exp_tx[i]) begin
                errs++;
                $display("FAIL %s tx cyc %0d: got %b want %b", tag, i, o_tx, exp_tx[i]);
            end
            vecs++;
            if (o_rdy !== exp_rdy[i]) begin
                errs++;
                $display("FAIL %s ready cyc %0d: got %b want %b", tag, i, o_rdy, exp_rdy[i]);
            end
            vecs++;
            if (o_act !== !exp_rdy[i]) begin
                errs++;
                $display("FAIL %s active cyc %0d: got %b want %b", tag, i, o_act, !exp_rdy[i]);
            end
            if (i == 1) begin
                vecs++;
                if (o_bs !== 16'd0) begin
                    errs++;
                    $display("FAIL %s bytes_sent frame start: got %0d want 0", tag, o_bs);
                end
            end
            if (exp_hs[i] && bi > 0) begin
                vecs++;
                if (o_bs !== 16'(bi % bmod)) begin
                    errs++;
                    $display("FAIL %s bytes_sent byte %0d: got %0d want %0d", tag, bi, o_bs, bi % bmod);
                end
            end
            @(posedge clk);
            #1;
            if (exp_hs[i]) begin
                bi++;
                if (bi < n) begin
                    tx_data = frame_q[bi];
                    tx_last = (bi == n - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = $urandom();
                    tx_last  = $urandom();
                end
            end
        end
        vecs++;
        if (o_bs !== 16'(n % bmod)) begin
            errs++;
            $display("FAIL %s bytes_sent end: got %0d want %0d", tag, o_bs, n % bmod);
        end
        tx_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            vecs++;
            if (o_tx !== 1'b1 || o_rdy !== 1'b1 || o_act !== 1'b0) begin
                errs++;
                $display("FAIL %s idle cyc %0d: tx/rdy/act got %b%b%b want 110", tag, i, o_tx, o_rdy, o_act);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        sel      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({tx_a, rdy_a, act_a} !== 3'b110 || bs_a !== 16'd0) begin
            errs++;
            $display("FAIL reset A: tx/rdy/act %b%b%b bs %0d want 110 bs 0", tx_a, rdy_a, act_a, bs_a);
        end
        vecs++;
        if ({tx_b, rdy_b, act_b} !== 3'b110 || bs_b !== 4'd0) begin
            errs++;
            $display("FAIL reset B: tx/rdy/act %b%b%b bs %0d want 110 bs 0", tx_b, rdy_b, act_b, bs_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle();
        sel = 1'b0;
        tx_data = $urandom();
        idle_check("idle", 100);
    endtask

    task automatic test_single();
        sel = 1'b0;
        frame_q = '{8'h55};
        check_frame("single55");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        frame_q = '{8'hA5, 8'h3C};
        check_frame("b2b");
        idle_check("b2b_gap", 3);
        frame_q = '{8'($urandom()), 8'($urandom())};
        check_frame("b2b_next");
    endtask

    task automatic test_reset_mid();
        sel      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tx_last  = 1'b1;
        @(posedge clk);                // handshake edge
        #1;
        tx_valid = 1'b0;
        repeat (17) @(posedge clk);    // now inside data bit 3
        #1;
        @(negedge clk);
        vecs++;
        if (o_tx !== 1'b1 || o_rdy !== 1'b0) begin
            errs++;
            $display("FAIL rstmid pre: tx/rdy got %b%b want 10", o_tx, o_rdy);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({o_tx, o_rdy, o_act} !== 3'b110 || o_bs !== 16'd0) begin
            errs++;
            $display("FAIL rstmid post: tx/rdy/act %b%b%b bs %0d want 110 bs 0", o_tx, o_rdy, o_act, o_bs);
        end
        @(posedge clk);
        #1;
        idle_check("rstmid_quiet", 50);
        frame_q = '{8'h12};
        check_frame("rstmid_12");
    endtask

    task automatic test_checksum();
        sel = 1'b0;
        frame_q = '{8'h01, 8'h02, 8'hFF};
        check_frame("csum");
    endtask

    task automatic test_wrap();
        sel = 1'b1;
        frame_q.delete();
        for (int k = 0; k < 17; k++) frame_q.push_back(8'($urandom()));
        check_frame("wrap17");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            sel = f[0];
            idle_check("rnd_gap", $urandom_range(1, 6));
            frame_q.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                frame_q.push_back(8'($urandom()));
            check_frame("rnd");
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_checksum();
        test_wrap();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
